// File: rtl/lcd_bus_responder.sv
// HD44780-compatible 16x2 LCD bus responder: decodes en/rs/rw/D cycles from the
// display driver and mirrors DDRAM into a 256-bit frame buffer.
module lcd_bus_responder #(
  parameter int unsigned BUSY_CYCLES  = 4,
  parameter int unsigned CLEAR_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         rs,
  input  logic         rw,
  input  logic [7:0]   d_in,
  output logic [7:0]   d_out,
  output logic         d_oe,
  output logic [255:0] message,
  output logic         frame_valid,
  output logic         busy,
  output logic         disp_on,
  output logic         err
);

  localparam int unsigned N_CHARS = 32;
  localparam int unsigned MAX_CYC = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  logic             en_s1_q, en_s2_q, en_s3_q;
  logic             rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q;
  logic [7:0]       d_s1_q, d_s2_q;

  logic [6:0]       ac_q, ac_d;
  logic             id_q, id_d;
  logic             cg_q, cg_d;
  logic             disp_on_q, disp_on_d;
  logic [7:0]       ddram_q [N_CHARS];
  logic [7:0]       ddram_d [N_CHARS];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             fv_q, fv_d;
  logic             err_q, err_d;
  logic             d_oe_q, d_oe_d;
  logic [7:0]       d_out_q, d_out_d;

  logic             rise, fall, vis, addr_ok;
  logic [4:0]       idx;
  logic [7:0]       rd_char;

  // AC walks line 1 (0x00-0x27) then line 2 (0x40-0x67), wrapping both ways
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    if (inc) begin
      if (ac == 7'h27)      ac_step = 7'h40;
      else if (ac == 7'h67) ac_step = 7'h00;
      else                  ac_step = ac + 7'd1;
    end else begin
      if (ac == 7'h00)      ac_step = 7'h67;
      else if (ac == 7'h40) ac_step = 7'h27;
      else                  ac_step = ac - 7'd1;
    end
  endfunction

  assign rise    = en_s2_q & ~en_s3_q;
  assign fall    = en_s3_q & ~en_s2_q;
  assign vis     = (ac_q[5:4] == 2'b00);
  assign idx     = {ac_q[6], ac_q[3:0]};
  assign rd_char = vis ? ddram_q[idx] : 8'h20;
  assign addr_ok = (d_s2_q[6:0] <= 7'h27) || ((d_s2_q[6:0] >= 7'h40) && (d_s2_q[6:0] <= 7'h67));

  always_comb begin
    ac_d      = ac_q;
    id_d      = id_q;
    cg_d      = cg_q;
    disp_on_d = disp_on_q;
    ddram_d   = ddram_q;
    cnt_d     = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
    fv_d      = 1'b0;
    err_d     = 1'b0;
    d_oe_d    = d_oe_q;
    d_out_d   = d_out_q;

    if (rise && rw_s2_q) begin
      d_oe_d  = 1'b1;
      d_out_d = rs_s2_q ? rd_char : {busy_q, ac_q};
    end

    if (fall) begin
      d_oe_d = 1'b0;
      if (rw_s2_q) begin
        if (rs_s2_q) ac_d = ac_step(ac_q, id_q);
      end else if (busy_q) begin
        err_d = 1'b1;
      end else if (rs_s2_q) begin
        cnt_d = CNT_W'(BUSY_CYCLES);
        if (!cg_q) begin
          if (vis) begin
            ddram_d[idx] = d_s2_q;
            fv_d         = 1'b1;
          end
          ac_d = ac_step(ac_q, id_q);
        end
      end else if (d_s2_q[7]) begin
        if (addr_ok) begin
          ac_d  = d_s2_q[6:0];
          cg_d  = 1'b0;
          cnt_d = CNT_W'(BUSY_CYCLES);
        end else begin
          err_d = 1'b1;
        end
      end else if (d_s2_q[6]) begin
        cg_d  = 1'b1;
        cnt_d = CNT_W'(BUSY_CYCLES);
      end else if (d_s2_q[5]) begin
        cnt_d = CNT_W'(BUSY_CYCLES);
      end else if (d_s2_q[4]) begin
        if (!d_s2_q[3]) ac_d = ac_step(ac_q, d_s2_q[2]);
        cnt_d = CNT_W'(BUSY_CYCLES);
      end else if (d_s2_q[3]) begin
        disp_on_d = d_s2_q[2];
        cnt_d     = CNT_W'(BUSY_CYCLES);
      end else if (d_s2_q[2]) begin
        id_d  = d_s2_q[1];
        cnt_d = CNT_W'(BUSY_CYCLES);
      end else if (d_s2_q[1]) begin
        ac_d  = 7'h00;
        cg_d  = 1'b0;
        cnt_d = CNT_W'(CLEAR_CYCLES);
      end else if (d_s2_q[0]) begin
        for (int i = 0; i < N_CHARS; i++) ddram_d[i] = 8'h20;
        ac_d  = 7'h00;
        id_d  = 1'b1;
        cg_d  = 1'b0;
        fv_d  = 1'b1;
        cnt_d = CNT_W'(CLEAR_CYCLES);
      end
    end

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      en_s1_q   <= 1'b0;
      en_s2_q   <= 1'b0;
      en_s3_q   <= 1'b0;
      rs_s1_q   <= 1'b0;
      rs_s2_q   <= 1'b0;
      rw_s1_q   <= 1'b0;
      rw_s2_q   <= 1'b0;
      d_s1_q    <= 8'h00;
      d_s2_q    <= 8'h00;
      ac_q      <= 7'h00;
      id_q      <= 1'b1;
      cg_q      <= 1'b0;
      disp_on_q <= 1'b0;
      for (int i = 0; i < N_CHARS; i++) ddram_q[i] <= 8'h20;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      fv_q      <= 1'b0;
      err_q     <= 1'b0;
      d_oe_q    <= 1'b0;
      d_out_q   <= 8'h00;
    end else begin
      // rs/rw/d travel with en so the decode sees the values sampled with the edge
      en_s1_q   <= en;
      en_s2_q   <= en_s1_q;
      en_s3_q   <= en_s2_q;
      rs_s1_q   <= rs;
      rs_s2_q   <= rs_s1_q;
      rw_s1_q   <= rw;
      rw_s2_q   <= rw_s1_q;
      d_s1_q    <= d_in;
      d_s2_q    <= d_s1_q;
      ac_q      <= ac_d;
      id_q      <= id_d;
      cg_q      <= cg_d;
      disp_on_q <= disp_on_d;
      ddram_q   <= ddram_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      fv_q      <= fv_d;
      err_q     <= err_d;
      d_oe_q    <= d_oe_d;
      d_out_q   <= d_out_d;
    end
  end

  for (genvar g = 0; g < N_CHARS; g++) begin : g_msg
    assign message[8*(N_CHARS-1-g) +: 8] = ddram_q[g];
  end

  assign d_out       = d_out_q;
  assign d_oe        = d_oe_q;
  assign frame_valid = fv_q;
  assign busy        = busy_q;
  assign disp_on     = disp_on_q;
  assign err         = err_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed self-checking bench for lcd_bus_responder: bus write/read cycles
// with hand-computed frame buffer, AC, busy and pulse expectations.
module tb_lcd_bus_responder;

  logic         clk;
  logic         reset;
  logic         en, rs, rw;
  logic [7:0]   d_in;
  logic [7:0]   d_out;
  logic         d_oe;
  logic [255:0] message;
  logic         frame_valid, busy, disp_on, err;

  int checks   = 0;
  int failures = 0;

  int n_fv, n_err, n_busy, fv_at, err_at, busy_at;
  logic [255:0] exp_msg;
  logic [7:0]   rd_val;
  logic         rd_oe, rd_pre, rd_post;
  int           fv_total;

  lcd_bus_responder dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .rs          (rs),
    .rw          (rw),
    .d_in        (d_in),
    .d_out       (d_out),
    .d_oe        (d_oe),
    .message     (message),
    .frame_valid (frame_valid),
    .busy        (busy),
    .disp_on     (disp_on),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // en high for 'hi' cycles, then watch 'mon' cycles after the fall (index 0 = edge k)
  task automatic bus_write(input logic r, input logic [7:0] d, input int hi, input int mon);
    @(negedge clk);
    rs = r; rw = 1'b0; d_in = d; en = 1'b1;
    repeat (hi) @(negedge clk);
    en = 1'b0;
    n_fv = 0; n_err = 0; n_busy = 0; fv_at = -1; err_at = -1; busy_at = -1;
    for (int i = 0; i < mon; i++) begin
      @(posedge clk); #1;
      if (frame_valid) begin n_fv++; if (fv_at < 0) fv_at = i; end
      if (err) begin n_err++; if (err_at < 0) err_at = i; end
      if (busy) begin n_busy++; if (busy_at < 0) busy_at = i; end
    end
  endtask

  task automatic bus_read(input logic r, output logic [7:0] val, output logic oe,
                          output logic pre_oe, output logic post_oe);
    @(negedge clk);
    rs = r; rw = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; pre_oe = d_oe;
    @(posedge clk); #1; oe = d_oe; val = d_out;
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(posedge clk);
    #1 post_oe = d_oe;
    @(negedge clk);
    rw = 1'b0;
  endtask

  initial begin
    en = 1'b0; rs = 1'b0; rw = 1'b0; d_in = 8'h00; reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    exp_msg = {32{8'h20}};

    // reset state
    chk("rst_message", message, exp_msg);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_disp_on", 256'(disp_on), 256'(0));
    chk("rst_fv", 256'(frame_valid), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    chk("rst_d_oe", 256'(d_oe), 256'(0));
    chk("rst_d_out", 256'(d_out), 256'(0));
    bus_read(1'b0, rd_val, rd_oe, rd_pre, rd_post);
    chk("rst_ac_read", 256'(rd_val), 256'(8'h00));
    chk("rd_oe_j1", 256'(rd_pre), 256'(0));
    chk("rd_oe_j2", 256'(rd_oe), 256'(1));
    chk("rd_oe_drop", 256'(rd_post), 256'(0));

    // set address 0x00, write 'A','B'
    bus_write(1'b0, 8'h80, 4, 8);
    chk("addr_fv", 256'(n_fv), 256'(0));
    chk("addr_busy_n", 256'(n_busy), 256'(4));
    chk("addr_busy_at", 256'(busy_at), 256'(2));
    bus_write(1'b1, 8'h41, 4, 8);
    chk("wa_fv_n", 256'(n_fv), 256'(1));
    chk("wa_fv_at", 256'(fv_at), 256'(2));
    chk("wa_busy_n", 256'(n_busy), 256'(4));
    bus_write(1'b1, 8'h42, 4, 8);
    chk("wb_fv_n", 256'(n_fv), 256'(1));
    chk("wb_busy_n", 256'(n_busy), 256'(4));
    exp_msg[255:248] = 8'h41;
    exp_msg[247:240] = 8'h42;
    chk("ab_message", message, exp_msg);

    // line 2 fill: 16 visible bytes, 17th lands at AC 0x50 and is dropped
    bus_write(1'b0, 8'hC0, 4, 8);
    fv_total = 0;
    for (int i = 0; i < 17; i++) begin
      bus_write(1'b1, 8'(8'h30 + i), 4, 8);
      fv_total += n_fv;
    end
    chk("l2_fv_total", 256'(fv_total), 256'(16));
    exp_msg[127:0] = 128'h303132333435363738393A3B3C3D3E3F;
    chk("l2_message", message, exp_msg);
    bus_read(1'b0, rd_val, rd_oe, rd_pre, rd_post);
    chk("l2_ac_read", 256'(rd_val), 256'(8'h51));

    // decrement mode wraps AC 0x00 -> 0x67
    bus_write(1'b0, 8'h04, 4, 8);
    bus_write(1'b0, 8'h80, 4, 8);
    bus_write(1'b1, 8'h5A, 4, 8);
    chk("z_fv_n", 256'(n_fv), 256'(1));
    exp_msg[255:248] = 8'h5A;
    chk("z_message", message, exp_msg);
    bus_read(1'b0, rd_val, rd_oe, rd_pre, rd_post);
    chk("z_ac_read", 256'(rd_val), 256'(8'h67));
    bus_read(1'b1, rd_val, rd_oe, rd_pre, rd_post);
    chk("invis_data_read", 256'(rd_val), 256'(8'h20));
    bus_read(1'b0, rd_val, rd_oe, rd_pre, rd_post);
    chk("rd_step_ac", 256'(rd_val), 256'(8'h66));

    // data write while busy is dropped with err
    bus_write(1'b0, 8'h80, 4, 1);
    bus_write(1'b1, 8'h51, 2, 8);
    chk("drop_err_n", 256'(n_err), 256'(1));
    chk("drop_err_at", 256'(err_at), 256'(2));
    chk("drop_fv_n", 256'(n_fv), 256'(0));
    chk("drop_message", message, exp_msg);
    bus_read(1'b1, rd_val, rd_oe, rd_pre, rd_post);
    chk("vis_data_read", 256'(rd_val), 256'(8'h5A));

    // clear display
    bus_write(1'b0, 8'h01, 4, 24);
    exp_msg = {32{8'h20}};
    chk("clr_busy_n", 256'(n_busy), 256'(16));
    chk("clr_busy_at", 256'(busy_at), 256'(2));
    chk("clr_fv_n", 256'(n_fv), 256'(1));
    chk("clr_message", message, exp_msg);

    // CGRAM mode swallows data; illegal DDRAM address leaves AC alone
    bus_write(1'b0, 8'h40, 4, 8);
    bus_write(1'b1, 8'h55, 4, 8);
    chk("cg_fv_n", 256'(n_fv), 256'(0));
    chk("cg_message", message, exp_msg);
    bus_write(1'b0, 8'h85, 4, 8);
    bus_write(1'b0, 8'hA8, 4, 8);
    chk("ill_err_n", 256'(n_err), 256'(1));
    chk("ill_busy_n", 256'(n_busy), 256'(0));
    bus_read(1'b0, rd_val, rd_oe, rd_pre, rd_post);
    chk("ill_ac_read", 256'(rd_val), 256'(8'h05));
    bus_write(1'b0, 8'h0C, 4, 8);
    chk("disp_on_set", 256'(disp_on), 256'(1));

    // reset lands between the en fall and its commit
    @(negedge clk);
    rs = 1'b1; rw = 1'b0; d_in = 8'h41; en = 1'b1;
    repeat (4) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n_fv = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (frame_valid) n_fv++;
    end
    chk("mid_rst_fv_n", 256'(n_fv), 256'(0));
    chk("mid_rst_message", message, exp_msg);
    chk("mid_rst_disp_on", 256'(disp_on), 256'(0));
    chk("mid_rst_busy", 256'(busy), 256'(0));
    chk("mid_rst_d_oe", 256'(d_oe), 256'(0));
    chk("mid_rst_d_out", 256'(d_out), 256'(0));
    chk("mid_rst_err", 256'(err), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
